// File: rtl/mesh_port_allocator_pkg.sv
// mesh_port_allocator_pkg: shared constants and helpers for the mesh router port allocator.
//   N_PORTS / SEL_W      : router port count and switch select width
//   CORE..WEST           : port index constants
//   lowest_set(v)        : keeps only the lowest set bit of a request vector
//   rr_inc(p)            : round-robin pointer increment, wrapping at the last port
package mesh_port_allocator_pkg;
    localparam int N_PORTS = 5;
    localparam int SEL_W   = $clog2(N_PORTS);
    localparam int CORE    = 0;
    localparam int NORTH   = 1;
    localparam int EAST    = 2;
    localparam int SOUTH   = 3;
    localparam int WEST    = 4;

    function automatic logic [N_PORTS-1:0] lowest_set(input logic [N_PORTS-1:0] v);
        return v & (~v + N_PORTS'(1));
    endfunction

    // Explicit compare: N_PORTS is not a power of two, so natural wrap is wrong.
    function automatic logic [SEL_W-1:0] rr_inc(input logic [SEL_W-1:0] p);
        return (p == SEL_W'(WEST)) ? SEL_W'(CORE) : p + SEL_W'(1);
    endfunction
endpackage

// File: rtl/mesh_rr_arbiter.sv
// mesh_rr_arbiter: one N_PORTS-way round-robin arbiter for a single output port.
//   clk, reset_n : clock, async active-low reset
//   i_req        : per-input request vector for this output
//   i_en         : output available (register empty or draining)
//   o_grant      : one-hot grant over inputs
//   o_idx        : index of the winning input
//   o_valid      : a grant is issued this cycle
module mesh_rr_arbiter #(
    parameter int N_PORTS = 5,
    parameter int SEL_W   = $clog2(N_PORTS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_PORTS-1:0] i_req,
    input  logic               i_en,
    output logic [N_PORTS-1:0] o_grant,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_valid
);
    import mesh_port_allocator_pkg::*;

    logic [SEL_W-1:0] ptr_q, ptr_d, cand;
    logic             hit;

    // Scan inputs starting at the pointer; the first requester wins.
    always_comb begin
        hit   = 1'b0;
        o_idx = '0;
        cand  = ptr_q;
        for (int j = 0; j < N_PORTS; j++) begin
            if (!hit && i_req[cand]) begin
                hit   = 1'b1;
                o_idx = cand;
            end
            cand = rr_inc(cand);
        end
        o_valid = hit && i_en;
        o_grant = o_valid ? N_PORTS'(1) << o_idx : '0;
        ptr_d   = o_valid ? rr_inc(o_idx) : ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
endmodule

// File: rtl/mesh_port_allocator.sv
// mesh_port_allocator: round-robin output-port allocator for the 5-port mesh router.
//   clk, reset_n : clock, async active-low reset
//   i_req        : per input, one-hot requested output (lowest bit wins if several)
//   i_en         : per output, downstream consumes the output register this cycle
//   o_grant      : per input, head flit taken (FIFO pop), combinational
//   o_sel        : per output, crossbar select; holds last value when idle
//   o_load       : per output, switch output register loads, combinational
//   o_data_val   : per output, registered, output register holds a valid flit
module mesh_port_allocator #(
    parameter int N_PORTS = 5,
    parameter int SEL_W   = $clog2(N_PORTS)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [0:N_PORTS-1][N_PORTS-1:0]     i_req,
    input  logic [0:N_PORTS-1]                  i_en,
    output logic [0:N_PORTS-1]                  o_grant,
    output logic [0:N_PORTS-1][SEL_W-1:0]       o_sel,
    output logic [0:N_PORTS-1]                  o_load,
    output logic [0:N_PORTS-1]                  o_data_val
);
    import mesh_port_allocator_pkg::*;

    logic [N_PORTS-1:0]            req_lsb [N_PORTS];
    logic [N_PORTS-1:0]            req_t   [N_PORTS];
    logic [N_PORTS-1:0]            gnt_t   [N_PORTS];
    logic [SEL_W-1:0]              idx     [N_PORTS];
    logic                          ld      [N_PORTS];
    logic [0:N_PORTS-1][SEL_W-1:0] sel_q, sel_d;
    logic [0:N_PORTS-1]            data_val_q, data_val_d;

    // Transpose per-input requests into per-output request vectors.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) req_lsb[i] = lowest_set(i_req[i]);
        for (int o = 0; o < N_PORTS; o++)
            for (int i = 0; i < N_PORTS; i++) req_t[o][i] = req_lsb[i][o];
    end

    for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
        mesh_rr_arbiter #(.N_PORTS(N_PORTS), .SEL_W(SEL_W)) u_arb (
            .clk     (clk),
            .reset_n (reset_n),
            .i_req   (req_t[o]),
            .i_en    (i_en[o] | ~data_val_q[o]),
            .o_grant (gnt_t[o]),
            .o_idx   (idx[o]),
            .o_valid (ld[o])
        );
    end

    always_comb begin
        o_grant = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            o_load[o] = ld[o];
            o_sel[o]  = ld[o] ? idx[o] : sel_q[o];
            for (int i = 0; i < N_PORTS; i++) o_grant[i] = o_grant[i] | gnt_t[o][i];
        end
        sel_d      = o_sel;
        data_val_d = o_load | (data_val_q & ~i_en);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q      <= '0;
            data_val_q <= '0;
        end else begin
            sel_q      <= sel_d;
            data_val_q <= data_val_d;
        end
    end

    assign o_data_val = data_val_q;
endmodule

// File: tb/tb_mesh_port_allocator.sv
// tb_mesh_port_allocator: scoreboard bench for mesh_port_allocator with directed vectors.
module tb_mesh_port_allocator;
    logic             clk = 1'b0;
    logic             reset_n;
    logic [0:4][4:0]  i_req;
    logic [0:4]       i_en;
    logic [0:4]       o_grant;
    logic [0:4][2:0]  o_sel;
    logic [0:4]       o_load;
    logic [0:4]       o_data_val;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    typedef struct packed {
        int              tag;
        logic [0:4]      g;
        logic [0:4][2:0] s;
        logic [0:4]      l;
        logic [0:4]      d;
    } exp_t;

    exp_t sb[$];

    mesh_port_allocator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (i_req),
        .i_en       (i_en),
        .o_grant    (o_grant),
        .o_sel      (o_sel),
        .o_load     (o_load),
        .o_data_val (o_data_val)
    );

    always #5 clk = ~clk;

    // Mask written with bit k = port k, mapped onto the [0:4] port vectors.
    function automatic logic [0:4] ob(input logic [4:0] m);
        logic [0:4] v;
        for (int k = 0; k < 5; k++) v[k] = m[k];
        return v;
    endfunction

    // Per-input requested output, -1 for no request.
    function automatic logic [0:4][4:0] rq(input int t0, t1, t2, t3, t4);
        logic [0:4][4:0] r;
        int t[5];
        t = '{t0, t1, t2, t3, t4};
        for (int i = 0; i < 5; i++) r[i] = (t[i] < 0) ? 5'd0 : 5'd1 << t[i];
        return r;
    endfunction

    function automatic logic [0:4][2:0] sv(input int s0, s1, s2, s3, s4);
        logic [0:4][2:0] r;
        r[0] = 3'(s0); r[1] = 3'(s1); r[2] = 3'(s2); r[3] = 3'(s3); r[4] = 3'(s4);
        return r;
    endfunction

    task automatic chk(input string n, input int tag, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", n, tag, act, req);
        end
    endtask

    task automatic step(input logic [0:4][4:0] r, input logic [0:4] en, input logic [0:4] g,
                        input logic [0:4][2:0] s, input logic [0:4] l, input logic [0:4] d);
        exp_t e;
        i_req = r;
        i_en  = en;
        step_no++;
        e.tag = step_no; e.g = g; e.s = s; e.l = l; e.d = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("grant",    e.tag, 16'(o_grant),    16'(e.g));
            chk("sel",      e.tag, 16'(o_sel),      16'(e.s));
            chk("load",     e.tag, 16'(o_load),     16'(e.l));
            chk("data_val", e.tag, 16'(o_data_val), 16'(e.d));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [0:4][4:0] raw;
        reset_n = 1'b0;
        i_req   = '0;
        i_en    = '1;
        #2;
        chk("reset_data_val", 0, 16'(o_data_val), 16'(ob(5'b00000)));
        chk("reset_grant",    0, 16'(o_grant),    16'(ob(5'b00000)));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle: no requests
        repeat (5) step(rq(-1,-1,-1,-1,-1), '1, ob(5'b00000), sv(0,0,0,0,0), ob(5'b00000), ob(5'b00000));

        // Inputs 1,2,3 contend for output 0
        step(rq(-1,0,0,0,-1), '1, ob(5'b00010), sv(1,0,0,0,0), ob(5'b00001), ob(5'b00000));
        step(rq(-1,0,0,0,-1), '1, ob(5'b00100), sv(2,0,0,0,0), ob(5'b00001), ob(5'b00001));
        step(rq(-1,0,0,0,-1), '1, ob(5'b01000), sv(3,0,0,0,0), ob(5'b00001), ob(5'b00001));
        step(rq(-1,0,0,0,-1), '1, ob(5'b00010), sv(1,0,0,0,0), ob(5'b00001), ob(5'b00001));
        step(rq(-1,-1,-1,-1,-1), '1, ob(5'b00000), sv(1,0,0,0,0), ob(5'b00000), ob(5'b00001));
        step(rq(-1,-1,-1,-1,-1), '1, ob(5'b00000), sv(1,0,0,0,0), ob(5'b00000), ob(5'b00000));

        // Input 4 -> output 2 with downstream blocked, then released
        step(rq(-1,-1,-1,-1,2), ob(5'b11011), ob(5'b10000), sv(1,0,4,0,0), ob(5'b00100), ob(5'b00000));
        step(rq(-1,-1,-1,-1,2), ob(5'b11011), ob(5'b00000), sv(1,0,4,0,0), ob(5'b00000), ob(5'b00100));
        step(rq(-1,-1,-1,-1,2), ob(5'b11011), ob(5'b00000), sv(1,0,4,0,0), ob(5'b00000), ob(5'b00100));
        step(rq(-1,-1,-1,-1,2), '1, ob(5'b10000), sv(1,0,4,0,0), ob(5'b00100), ob(5'b00100));
        step(rq(-1,-1,-1,-1,-1), '1, ob(5'b00000), sv(1,0,4,0,0), ob(5'b00000), ob(5'b00100));
        step(rq(-1,-1,-1,-1,-1), '1, ob(5'b00000), sv(1,0,4,0,0), ob(5'b00000), ob(5'b00000));

        // Full permutation: every input to a distinct output
        step(rq(4,3,2,1,0), '1, ob(5'b11111), sv(4,3,2,1,0), ob(5'b11111), ob(5'b00000));
        step(rq(4,3,2,1,0), '1, ob(5'b11111), sv(4,3,2,1,0), ob(5'b11111), ob(5'b11111));

        // Asynchronous reset mid-stream
        chk("pre_reset_data_val", 0, 16'(o_data_val), 16'(ob(5'b11111)));
        i_req   = '0;
        reset_n = 1'b0;
        #1;
        chk("async_data_val", 0, 16'(o_data_val), 16'(ob(5'b00000)));
        chk("async_sel",      0, 16'(o_sel),      16'(sv(0,0,0,0,0)));
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Pointers back at 0: out2 picks input 1 over 3, out4 picks input 0 over 4
        step(rq(4,2,-1,2,4), '1, ob(5'b00011), sv(0,0,1,0,0), ob(5'b10100), ob(5'b00000));

        // Multi-bit request from input 0: only output 1 is used
        raw    = '0;
        raw[0] = 5'b00110;
        step(raw, '1, ob(5'b00001), sv(0,0,1,0,0), ob(5'b00010), ob(5'b10100));
        step(raw, '1, ob(5'b00001), sv(0,0,1,0,0), ob(5'b00010), ob(5'b00010));
        step(rq(-1,-1,-1,-1,-1), '1, ob(5'b00000), sv(0,0,1,0,0), ob(5'b00000), ob(5'b00010));

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 0, 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
